io_input_conditioner: RTL

//   Input-side companion of the tri-state pad cell: conditions the raw level read back from a pad.
//   Per bit it synchronises the asynchronous pad level and debounces it.
//   It also produces one-cycle rise/fall pulses and keeps sticky, maskable interrupt flags.

---
 rtl/io_input_conditioner.sv | 89 ++++++++
 1 files changed

// File: rtl/io_input_conditioner.sv
// Input conditioner for pad read-back levels.
// Per bit: multi-flop synchroniser, stable-count debouncer, one-cycle edge
// pulses and sticky, maskable interrupt flags. Everything is in the clk domain.
module io_input_conditioner #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] data_q,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Reject parameter values the structure cannot support.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("io_input_conditioner: DB_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_next;
  logic [WIDTH-1:0]                  data_next;
  logic [WIDTH-1:0]                  set;

  // Plain flop chain; the pad level feeds nothing but stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // Debounce: count consecutive cycles of disagreement, accept on the last one.
  always_comb begin
    data_next = data_q;
    cnt_next  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync[i] != data_q[i]) begin
        if (cnt[i] == CNT_LAST) begin
          data_next[i] = sync[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge flags requesting an interrupt this cycle.
  assign set = (rise_o & rise_en) | (fall_o & fall_en);

  // Debounced level, edge pulses and sticky flags, all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      data_q     <= '0;
      rise_o     <= '0;
      fall_o     <= '0;
      irq_status <= '0;
    end else begin
      cnt        <= cnt_next;
      data_q     <= data_next;
      rise_o     <= data_next & ~data_q;
      fall_o     <= ~data_next & data_q;
      irq_status <= (irq_status & ~irq_clr) | set;
    end
  end

  // Summary interrupt straight from the registered flags.
  assign irq = |irq_status;

endmodule
